id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage MIPS core.
- Latches decoded ALU operation, result select, both operands, destination register and write-enable on each clock edge.
- Supports stall, flush and bubble insertion.
- While execute is stalled, refreshes held operands from the write-back bus so a stalled instruction never executes with stale source data.

Parameters:
- STALL_W, 6, width of the core-wide stall vector; bit 2 = decode stalled, bit 3 = execute stalled.
- NOP_ALUOP, 8'h00, aluop value driven for a bubble (equals EXE_NOP_OP).
- NOP_ALUSEL, 3'b000, alusel value driven for a bubble (equals EXE_RES_NOP).

Ports:
- Clk  in  1  core clock, rising-edge.
- Rst_n  in  1  asynchronous reset, active-high: asserted = 1'b1. Polarity and asynchronous behaviour are fixed for this block.
- stall  in  STALL_W  core stall vector from the control unit.
- flush  in  1  pipeline flush (exception/redirect); overrides stall.
- id_aluop  in  8  decoded ALU operation.
- id_alusel  in  3  decoded result select.
- id_reg1, id_reg2  in  32 each  decoded operands (already forwarded or immediate).
- id_reg1_read, id_reg2_read  in  1 each  operand is a register read.
- id_reg1_addr, id_reg2_addr  in  5 each  source register numbers.
- id_wd  in  5  destination register.
- id_wreg  in  1  destination write enable.
- wb_wreg  in  1  write-back port write enable.
- wb_wd  in  5  write-back port register number.
- wb_wdata  in  32  write-back port data.
- ex_aluop  out  8  held ALU operation.
- ex_alusel  out  3  held result select.
- ex_reg1, ex_reg2  out  32 each  held operands.
- ex_wd  out  5  held destination register.
- ex_wreg  out  1  held write enable.
- ex_valid  out  1  1 = a real instruction is held; 0 = bubble.

Behaviour:
- Reset (Rst_n=1, asynchronous):
  - ex_aluop=NOP_ALUOP, ex_alusel=NOP_ALUSEL.
  - ex_reg1=ex_reg2=0, ex_wd=0, ex_wreg=0, ex_valid=0.
  - Held read flags and held source addresses = 0.
- Priority at each rising Clk edge, highest first:
  1. flush=1: load a bubble (NOP aluop/alusel, operands 0, wd 0, wreg 0, valid 0). Applies regardless of stall.
  2. stall[2]=1 and stall[3]=0: load a bubble. Decode is held, execute advances.
  3. stall[2]=1 and stall[3]=1: hold all fields (see operand refresh below).
  4. stall[2]=0: capture all id_* inputs and set ex_valid=1.
- stall[2]=0 with stall[3]=1 is illegal. Behave as case 4. A verification assertion flags it.
- Operand refresh (hold case only), evaluated for each operand n:
  - Condition: held reg_n_read=1, wb_wreg=1, wb_wd equals held reg_n_addr, and that address is non-zero.
  - Action: ex_reg_n takes wb_wdata at the edge.
  - Register 0 is never refreshed.
  - Both operands may refresh in the same edge.
- Immediate operands (read flag 0) are never refreshed.
- Latency: 1 cycle from id_* to ex_*. Outputs are registered only, with no combinational input-to-output path.
- Mid-operation reset clears everything immediately, independent of Clk.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- When defined, adds:
  - Output bubble_cnt, 16 bits: increments on every edge where a bubble is loaded (flush or decode-only stall). Saturates at 16'hFFFF; reset to 0.
  - Output refresh_cnt, 16 bits: increments once per edge with at least one operand refresh. Same saturation and reset.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then ORI decode (aluop=EXE_OR_OP, reg1=32'h1234, wd=5, wreg=1), stall=0 -> next edge: ex_reg1=32'h1234, ex_wd=5, ex_wreg=1, ex_valid=1. Reset asserted mid-cycle -> all outputs 0 at once.
- stall=6'b000100 -> next edge: ex_aluop=NOP_ALUOP, ex_wreg=0, ex_valid=0. Same input with stall=0 next -> captured normally.
- stall=6'b001100 for 3 cycles with changing id_* -> ex_* unchanged across all 3 edges.
- Hold with reg1_read=1, reg1_addr=7; wb_wreg=1, wb_wd=7, wb_wdata=32'hDEAD_BEEF -> ex_reg1=32'hDEADBEEF after the edge. With wb_wd=0 and held addr 0 -> no change. With reg1_read=0 -> no change.
- flush=1 with stall=6'b001100 -> bubble loaded, ex_valid=0.
- With ID_EX_BUBBLE_CNT_EN: 5 bubble edges, then 2 refresh edges -> bubble_cnt=5, refresh_cnt=2. Preload 16'hFFFF -> stays at 16'hFFFF.

Source files
------------

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register for the 5-stage MIPS core.
// Handles flush, bubble insertion and hold. While held, an operand that came
// from a register read is refreshed from the write-back port.
// Optional macro ID_EX_BUBBLE_CNT_EN adds saturating bubble/refresh counters.
module id_ex_reg #(
    parameter int unsigned STALL_W    = 6,
    parameter logic [7:0]  NOP_ALUOP  = 8'h00,
    parameter logic [2:0]  NOP_ALUSEL = 3'b000
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [7:0]         id_aluop,
    input  logic [2:0]         id_alusel,
    input  logic [31:0]        id_reg1,
    input  logic [31:0]        id_reg2,
    input  logic               id_reg1_read,
    input  logic               id_reg2_read,
    input  logic [4:0]         id_reg1_addr,
    input  logic [4:0]         id_reg2_addr,
    input  logic [4:0]         id_wd,
    input  logic               id_wreg,
    input  logic               wb_wreg,
    input  logic [4:0]         wb_wd,
    input  logic [31:0]        wb_wdata,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [15:0]        bubble_cnt,
    output logic [15:0]        refresh_cnt,
`endif
    output logic [7:0]         ex_aluop,
    output logic [2:0]         ex_alusel,
    output logic [31:0]        ex_reg1,
    output logic [31:0]        ex_reg2,
    output logic [4:0]         ex_wd,
    output logic               ex_wreg,
    output logic               ex_valid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 16;

    logic [7:0]        aluop_q,  aluop_d;
    logic [2:0]        alusel_q, alusel_d;
    logic [DATA_W-1:0] reg1_q,   reg1_d;
    logic [DATA_W-1:0] reg2_q,   reg2_d;
    logic              rd1_q,    rd1_d;
    logic              rd2_q,    rd2_d;
    logic [ADDR_W-1:0] addr1_q,  addr1_d;
    logic [ADDR_W-1:0] addr2_q,  addr2_d;
    logic [ADDR_W-1:0] wd_q,     wd_d;
    logic              wreg_q,   wreg_d;
    logic              valid_q,  valid_d;

    logic bubble_c;
    logic hold_c;
    logic refresh1_c;
    logic refresh2_c;

    // Decode the stall/flush priority and the per-operand refresh conditions
    always_comb begin
        bubble_c   = flush | (stall[2] & ~stall[3]);
        hold_c     = ~flush & stall[2] & stall[3];
        refresh1_c = hold_c & rd1_q & wb_wreg & (wb_wd == addr1_q) & (addr1_q != '0);
        refresh2_c = hold_c & rd2_q & wb_wreg & (wb_wd == addr2_q) & (addr2_q != '0);
    end

    // Next-state selection: bubble, hold with refresh, or capture
    always_comb begin
        aluop_d  = aluop_q;
        alusel_d = alusel_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        valid_d  = valid_q;
        if (bubble_c) begin
            // A bubble also drops its read flags so it can never be refreshed
            aluop_d  = NOP_ALUOP;
            alusel_d = NOP_ALUSEL;
            reg1_d   = '0;
            reg2_d   = '0;
            rd1_d    = 1'b0;
            rd2_d    = 1'b0;
            addr1_d  = '0;
            addr2_d  = '0;
            wd_d     = '0;
            wreg_d   = 1'b0;
            valid_d  = 1'b0;
        end else if (hold_c) begin
            if (refresh1_c) reg1_d = wb_wdata;
            if (refresh2_c) reg2_d = wb_wdata;
        end else begin
            // stall[2]=0 captures, including the illegal stall[3]-only case
            aluop_d  = id_aluop;
            alusel_d = id_alusel;
            reg1_d   = id_reg1;
            reg2_d   = id_reg2;
            rd1_d    = id_reg1_read;
            rd2_d    = id_reg2_read;
            addr1_d  = id_reg1_addr;
            addr2_d  = id_reg2_addr;
            wd_d     = id_wd;
            wreg_d   = id_wreg;
            valid_d  = 1'b1;
        end
    end

    // Pipeline state register with asynchronous reset to a bubble
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            aluop_q  <= NOP_ALUOP;
            alusel_q <= NOP_ALUSEL;
            reg1_q   <= '0;
            reg2_q   <= '0;
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            aluop_q  <= aluop_d;
            alusel_q <= alusel_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            valid_q  <= valid_d;
        end
    end

    assign ex_aluop  = aluop_q;
    assign ex_alusel = alusel_q;
    assign ex_reg1   = reg1_q;
    assign ex_reg2   = reg2_q;
    assign ex_wd     = wd_q;
    assign ex_wreg   = wreg_q;
    assign ex_valid  = valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;

    // Saturating event counters
    always_comb begin
        bubble_cnt_d  = bubble_cnt_q;
        refresh_cnt_d = refresh_cnt_q;
        if (bubble_c && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        if ((refresh1_c || refresh2_c) && (refresh_cnt_q != '1))
            refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            bubble_cnt_q  <= '0;
            refresh_cnt_q <= '0;
        end else begin
            bubble_cnt_q  <= bubble_cnt_d;
            refresh_cnt_q <= refresh_cnt_d;
        end
    end

    assign bubble_cnt  = bubble_cnt_q;
    assign refresh_cnt = refresh_cnt_q;
`endif

    // Execute stalled while decode runs is an illegal stall vector
    illegal_stall_a: assert property (@(posedge Clk) disable iff (Rst_n)
                                      (stall[2] || !stall[3]));

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed plan steps followed by random stimulus,
// checked against a transaction-level model of the held instruction.
module tb_id_ex_reg;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1, id_reg2;
    logic        id_reg1_read, id_reg2_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr, id_wd;
    logic        id_wreg;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_valid;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt, refresh_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model of the instruction currently held in execute
    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] op1, op2;
        logic        rd1, rd2;
        logic [4:0]  a1, a2, wd;
        logic        wreg, valid;
    } instr_t;
    instr_t m;
    int unsigned m_bcnt, m_rcnt;

    id_ex_reg dut (
        .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush),
        .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg1(id_reg1), .id_reg2(id_reg2),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
        .id_wd(id_wd), .id_wreg(id_wreg),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_cnt(bubble_cnt), .refresh_cnt(refresh_cnt),
`endif
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_valid(ex_valid)
    );

    always #5 Clk = ~Clk;

    function automatic instr_t nop_instr();
        instr_t n;
        n.aluop = 8'h00; n.alusel = 3'b000; n.op1 = 0; n.op2 = 0;
        n.rd1 = 0; n.rd2 = 0; n.a1 = 0; n.a2 = 0; n.wd = 0; n.wreg = 0; n.valid = 0;
        return n;
    endfunction

    task automatic model_reset();
        m = nop_instr();
        m_bcnt = 0;
        m_rcnt = 0;
    endtask

    // One clock edge worth of the decode->execute rules
    task automatic model_edge();
        bit r1, r2;
        if (flush || (stall[2] && !stall[3])) begin
            m = nop_instr();
            if (m_bcnt < 65535) m_bcnt++;
        end else if (stall[2] && stall[3]) begin
            r1 = m.rd1 && wb_wreg && (wb_wd == m.a1) && (m.a1 != 0);
            r2 = m.rd2 && wb_wreg && (wb_wd == m.a2) && (m.a2 != 0);
            if (r1) m.op1 = wb_wdata;
            if (r2) m.op2 = wb_wdata;
            if ((r1 || r2) && m_rcnt < 65535) m_rcnt++;
        end else begin
            m.aluop = id_aluop; m.alusel = id_alusel;
            m.op1 = id_reg1; m.op2 = id_reg2;
            m.rd1 = id_reg1_read; m.rd2 = id_reg2_read;
            m.a1 = id_reg1_addr; m.a2 = id_reg2_addr;
            m.wd = id_wd; m.wreg = id_wreg; m.valid = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("aluop",  32'(ex_aluop),  32'(m.aluop));
        chk("alusel", 32'(ex_alusel), 32'(m.alusel));
        chk("reg1",   ex_reg1,        m.op1);
        chk("reg2",   ex_reg2,        m.op2);
        chk("wd",     32'(ex_wd),     32'(m.wd));
        chk("wreg",   32'(ex_wreg),   32'(m.wreg));
        chk("valid",  32'(ex_valid),  32'(m.valid));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_cnt",  32'(bubble_cnt),  m_bcnt);
        chk("refresh_cnt", 32'(refresh_cnt), m_rcnt);
`endif
    endtask

    // Edge, then sample 1 time unit later, then return at the next negedge
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
        @(negedge Clk);
    endtask

    task automatic set_id(input logic [7:0] op, input logic [31:0] r1, input logic rd1,
                          input logic [4:0] a1, input logic [4:0] wd, input logic wr);
        id_aluop = op; id_alusel = 3'b001;
        id_reg1 = r1; id_reg1_read = rd1; id_reg1_addr = a1;
        id_reg2 = 32'h0000_00FF; id_reg2_read = 1'b0; id_reg2_addr = 5'd0;
        id_wd = wd; id_wreg = wr;
    endtask

    task automatic randomize_id();
        id_aluop = 8'($urandom); id_alusel = 3'($urandom);
        id_reg1 = $urandom; id_reg2 = $urandom;
        id_reg1_read = 1'($urandom); id_reg2_read = 1'($urandom);
        id_reg1_addr = 5'($urandom_range(0, 7)); id_reg2_addr = 5'($urandom_range(0, 7));
        id_wd = 5'($urandom); id_wreg = 1'($urandom);
    endtask

    initial begin
        Rst_n = 1'b1; stall = 6'b0; flush = 1'b0;
        set_id(8'h00, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        model_reset();
        @(negedge Clk);
        #1;
        check_all();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b0;

        // ORI capture
        set_id(8'h25, 32'h0000_1234, 1'b1, 5'd3, 5'd5, 1'b1);
        step();
        chk("ori_reg1", ex_reg1, 32'h0000_1234);
        chk("ori_wd", 32'(ex_wd), 32'd5);
        chk("ori_wreg", 32'(ex_wreg), 32'd1);
        chk("ori_valid", 32'(ex_valid), 32'd1);

        // Mid-cycle reset clears at once
        #1 Rst_n = 1'b1;
        #1;
        model_reset();
        chk("midrst_reg1", ex_reg1, 32'd0);
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        check_all();
        #1 Rst_n = 1'b0;

        // Decode-only stall inserts a bubble, then same input captures
        stall = 6'b000100;
        step();
        chk("bub_aluop", 32'(ex_aluop), 32'd0);
        chk("bub_wreg", 32'(ex_wreg), 32'd0);
        chk("bub_valid", 32'(ex_valid), 32'd0);
        stall = 6'b000000;
        step();
        chk("recap_reg1", ex_reg1, 32'h0000_1234);
        chk("recap_valid", 32'(ex_valid), 32'd1);

        // Hold for three edges with changing decode inputs
        stall = 6'b001100;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step();
            chk("hold_reg1", ex_reg1, 32'h0000_1234);
            chk("hold_wd", 32'(ex_wd), 32'd5);
            chk("hold_aluop", 32'(ex_aluop), 32'h25);
        end

        // Refresh of a register-read operand
        stall = 6'b0;
        set_id(8'h21, 32'h0000_0011, 1'b1, 5'd7, 5'd9, 1'b1);
        step();
        stall = 6'b001100;
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEAD_BEEF;
        step();
        chk("refresh_reg1", ex_reg1, 32'hDEAD_BEEF);

        // Register 0 is never refreshed
        stall = 6'b0; wb_wreg = 1'b0;
        set_id(8'h21, 32'h0000_0022, 1'b1, 5'd0, 5'd9, 1'b1);
        step();
        stall = 6'b001100;
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hCAFE_F00D;
        step();
        chk("r0_norefresh", ex_reg1, 32'h0000_0022);

        // Immediate operand is never refreshed
        stall = 6'b0; wb_wreg = 1'b0;
        set_id(8'h25, 32'h0000_0033, 1'b0, 5'd7, 5'd9, 1'b1);
        step();
        stall = 6'b001100;
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h5555_AAAA;
        step();
        chk("imm_norefresh", ex_reg1, 32'h0000_0033);

        // Flush overrides a full stall
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_reg1", ex_reg1, 32'd0);
        flush = 1'b0;

        // Random legal stimulus
        for (int i = 0; i < 400; i++) begin
            int unsigned k;
            randomize_id();
            k = $urandom_range(0, 3);
            stall = 6'($urandom) & 6'b110011;
            if (k == 1) stall[2] = 1'b1;
            else if (k >= 2) stall[3:2] = 2'b11;
            flush = ($urandom_range(0, 7) == 0);
            wb_wreg = 1'($urandom);
            case ($urandom_range(0, 2))
                0: wb_wd = m.a1;
                1: wb_wd = m.a2;
                default: wb_wd = 5'($urandom_range(0, 7));
            endcase
            wb_wdata = $urandom;
            step();
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Saturation of the bubble counter
        flush = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge Clk);
            model_edge();
        end
        @(negedge Clk);
        chk("bubble_sat", 32'(bubble_cnt), 32'h0000_FFFF);
        check_all();
        flush = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
